booth_serial_mac: RTL

- Serial radix-4 Booth multiplier datapath and controller, directly downstream of the multiplicand register stage.
- Consumes the registered multiplicand in three forms: x, ~x and x<<1.
- Recodes the multiplier y two bits per cycle into a Booth digit in {-2,-1,0,+1,+2}.
- Accumulates one partial product per cycle and delivers the signed 2*WIDTH-bit product after WIDTH/2 iterations.

---
 rtl/booth_serial_mac_if.sv | 22 ++
 rtl/booth_serial_mac.sv | 67 ++++++
 2 files changed

// File: rtl/booth_serial_mac_if.sv
// booth_serial_mac_if: operand, handshake and result bundle for the serial Booth MAC.
interface booth_serial_mac_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     x_out;
  logic [WIDTH-1:0]     x_bar;
  logic [WIDTH:0]       x_shift;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic [2:0]           digit;
  logic [2*WIDTH-1:0]   product;
  modport master (
    output start, x_out, x_bar, x_shift, y,
    input  busy, done, digit, product
  );
  modport slave (
    input  start, x_out, x_bar, x_shift, y,
    output busy, done, digit, product
  );
endinterface

// File: rtl/booth_serial_mac.sv
// booth_serial_mac: serial radix-4 Booth multiplier, one Booth digit per cycle.
module booth_serial_mac #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  booth_serial_mac_if.slave bus
);
  localparam int CW = $clog2(WIDTH / 2);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] rec;
  logic [WIDTH+1:0] acc_hi, pp, sum, hi_next;
  logic [WIDTH-1:0] acc_lo, lo_next;
  logic [2:0] b, d;
  assign b = rec[2:0];
  // Negative digits add the inverted multiplicand and supply the +1 via carry-in.
  always_comb begin
    d = b == 3'b011 ? 3'b010 :
        b == 3'b100 ? 3'b110 :
        (b == 3'b001 || b == 3'b010) ? 3'b001 :
        (b == 3'b101 || b == 3'b110) ? 3'b111 : 3'b000;
    pp = d == 3'b001 ? {{2{bus.x_out[WIDTH-1]}}, bus.x_out} :
         d == 3'b010 ? {bus.x_shift[WIDTH], bus.x_shift} :
         d == 3'b110 ? {bus.x_bar[WIDTH-1], bus.x_bar, 1'b1} :
         d == 3'b111 ? {{2{bus.x_bar[WIDTH-1]}}, bus.x_bar} : '0;
    sum = acc_hi + pp + (WIDTH+2)'(d[2]);
    hi_next = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    lo_next = {sum[1:0], acc_lo[WIDTH-1:2]};
  end
  assign bus.digit = state == RUN ? d : 3'b000;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
      cnt         <= '0;
      rec         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state != RUN) begin
        state    <= bus.start ? RUN : IDLE;
        bus.busy <= bus.start;
        if (bus.start) begin
          rec    <= {bus.y, 1'b0};
          acc_hi <= '0;
          acc_lo <= '0;
          cnt    <= '0;
        end
      end else begin
        rec    <= {{2{rec[WIDTH]}}, rec[WIDTH:2]};
        acc_hi <= hi_next;
        acc_lo <= lo_next;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(WIDTH / 2 - 1)) begin
          state       <= DONE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          bus.product <= {hi_next[WIDTH-1:0], lo_next};
        end
      end
    end
endmodule
